// File: rtl/somador_serial.sv
// somador_serial: multi-cycle signed adder/subtractor.
// Operands are consumed CHUNK bits per cycle, least-significant chunk first,
// with the ripple carry held in a register between cycles. Signed overflow is
// reported and the result can optionally be clamped to the signed limits.
module somador_serial #(
    parameter int WIDTH  = 9,
    parameter int CHUNK  = 3,
    parameter int SATURA = 0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_inicio,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sinal,
    output logic             o_ocupado,
    output logic             o_pronto,
    output logic [WIDTH-1:0] o_soma,
    output logic             o_overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] ULTIMO  = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        FIM
    } estado_t;

    estado_t          r_estado;
    logic [WIDTH-1:0] r_op_a;      // shifts right one chunk per cycle
    logic [WIDTH-1:0] r_op_b;      // already inverted for subtraction
    logic [WIDTH-1:0] r_parcial;   // result chunks enter from the top
    logic [WIDTH-1:0] r_soma;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_ocupado;
    logic             r_pronto;
    logic             r_overflow;

    logic [CHUNK-1:0]       w_chunk_a;
    logic [CHUNK-1:0]       w_chunk_b;
    logic [CHUNK:0]         w_chunk_soma;
    logic [WIDTH+CHUNK-1:0] w_concat;
    logic [WIDTH-1:0]       w_parcial;
    logic                   w_carry_msb;
    logic                   w_overflow;
    logic [WIDTH-1:0]       w_final;

    // Chunk adder on the low chunk of the shifting operands, plus the
    // overflow/saturation view that only matters on the last chunk.
    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment), otherwise a latch is inferred.
    always_comb begin
        w_chunk_a    = r_op_a[CHUNK-1:0];
        w_chunk_b    = r_op_b[CHUNK-1:0];
        w_chunk_soma = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{CHUNK{1'b0}}, r_carry};
        w_concat     = {w_chunk_soma[CHUNK-1:0], r_parcial};
        w_parcial    = w_concat[WIDTH+CHUNK-1:CHUNK];
        // Carry into the word MSB recovered from the MSB sum bit of this chunk.
        w_carry_msb  = w_chunk_a[CHUNK-1] ^ w_chunk_b[CHUNK-1] ^ w_chunk_soma[CHUNK-1];
        w_overflow   = w_carry_msb ^ w_chunk_soma[CHUNK];
        w_final      = w_parcial;
        if ((SATURA != 0) && w_overflow) begin
            // On the last chunk w_chunk_a's MSB is op_a's sign bit.
            w_final = w_chunk_a[CHUNK-1] ? MIN_NEG : MAX_POS;
        end
    end

    // Control FSM and datapath registers; reset wins over any start request.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado   <= OCIOSO;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_parcial  <= '0;
            r_soma     <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (i_inicio) begin
                        r_op_a    <= i_a;
                        r_op_b    <= i_sinal ? ~i_b : i_b;
                        // a - b is a + ~b + 1: the +1 enters as the initial carry.
                        r_carry   <= i_sinal;
                        r_cnt     <= '0;
                        r_parcial <= '0;
                        r_ocupado <= 1'b1;
                        r_estado  <= CALCULA;
                    end
                end
                CALCULA: begin
                    r_op_a    <= r_op_a >> CHUNK;
                    r_op_b    <= r_op_b >> CHUNK;
                    r_parcial <= w_parcial;
                    r_carry   <= w_chunk_soma[CHUNK];
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == ULTIMO) begin
                        r_soma     <= w_final;
                        r_overflow <= w_overflow;
                        r_pronto   <= 1'b1;
                        r_estado   <= FIM;
                    end
                end
                FIM: begin
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: begin
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign o_ocupado  = r_ocupado;
    assign o_pronto   = r_pronto;
    assign o_soma     = r_soma;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_somador_serial.sv
// Testbench for somador_serial: three instances (9/3 wrap, 9/3 saturating,
// 16/4 wrap). Stimulus pushes hand-computed results into per-instance queues;
// monitors pop and compare whenever pronto is seen.
module tb_somador_serial;

    localparam int N1 = 3;
    localparam int N2 = 4;

    typedef struct packed {
        logic [15:0] soma;
        logic        ovf;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        inicio1, sinal1, inicio2, sinal2;
    logic [8:0]  a1, b1;
    logic [15:0] a2, b2;

    logic        ocup_w, pronto_w, ovf_w;
    logic [8:0]  soma_w;
    logic        ocup_s, pronto_s, ovf_s;
    logic [8:0]  soma_s;
    logic        ocup_2, pronto_2, ovf_2;
    logic [15:0] soma_2;

    exp_t q_w[$];
    exp_t q_s[$];
    exp_t q_2[$];
    exp_t e_w, e_s, e_2;

    int n_cmp = 0;
    int n_err = 0;

    somador_serial #(.WIDTH(9), .CHUNK(3), .SATURA(0)) dut_w (
        .i_clock(clock), .i_reset(reset), .i_inicio(inicio1),
        .i_a(a1), .i_b(b1), .i_sinal(sinal1),
        .o_ocupado(ocup_w), .o_pronto(pronto_w), .o_soma(soma_w), .o_overflow(ovf_w)
    );

    somador_serial #(.WIDTH(9), .CHUNK(3), .SATURA(1)) dut_s (
        .i_clock(clock), .i_reset(reset), .i_inicio(inicio1),
        .i_a(a1), .i_b(b1), .i_sinal(sinal1),
        .o_ocupado(ocup_s), .o_pronto(pronto_s), .o_soma(soma_s), .o_overflow(ovf_s)
    );

    somador_serial #(.WIDTH(16), .CHUNK(4), .SATURA(0)) dut_2 (
        .i_clock(clock), .i_reset(reset), .i_inicio(inicio2),
        .i_a(a2), .i_b(b2), .i_sinal(sinal2),
        .o_ocupado(ocup_2), .o_pronto(pronto_2), .o_soma(soma_2), .o_overflow(ovf_2)
    );

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nome, got, exp, $time);
        end
    endtask

    // Monitors: every pronto must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (pronto_w) begin
            if (q_w.size() == 0) check("pronto_w_extra", 32'(pronto_w), 32'd0);
            else begin
                e_w = q_w.pop_front();
                check("soma_w", 32'(soma_w), 32'(e_w.soma[8:0]));
                check("ovf_w", 32'(ovf_w), 32'(e_w.ovf));
            end
        end
    end

    always @(negedge clock) begin
        if (pronto_s) begin
            if (q_s.size() == 0) check("pronto_s_extra", 32'(pronto_s), 32'd0);
            else begin
                e_s = q_s.pop_front();
                check("soma_s", 32'(soma_s), 32'(e_s.soma[8:0]));
                check("ovf_s", 32'(ovf_s), 32'(e_s.ovf));
            end
        end
    end

    always @(negedge clock) begin
        if (pronto_2) begin
            if (q_2.size() == 0) check("pronto_2_extra", 32'(pronto_2), 32'd0);
            else begin
                e_2 = q_2.pop_front();
                check("soma_2", 32'(soma_2), 32'(e_2.soma));
                check("ovf_2", 32'(ovf_2), 32'(e_2.ovf));
            end
        end
    end

    // One operation on the 9-bit pair; inputs are scrambled right after the
    // accept edge, and optionally inicio is pulsed during CALCULA.
    task automatic op1(input string nome, input logic [8:0] a, input logic [8:0] b,
                       input logic s, input logic [8:0] sw, input logic ow,
                       input logic [8:0] ss, input logic os, input bit pulso);
        int lat;
        int n_ocup;
        @(negedge clock);
        a1 = a; b1 = b; sinal1 = s; inicio1 = 1'b1;
        @(posedge clock); #1;
        q_w.push_back({7'd0, sw, ow});
        q_s.push_back({7'd0, ss, os});
        inicio1 = 1'b0; a1 = ~a; b1 = ~b; sinal1 = ~s;
        lat = -1;
        n_ocup = 0;
        for (int c = 0; c < 20; c++) begin
            if (!ocup_w) break;
            n_ocup++;
            if (pronto_w && lat < 0) lat = c;
            if (pulso) inicio1 = (c == 1);
            @(posedge clock); #1;
        end
        inicio1 = 1'b0;
        check({nome, "_lat"}, 32'(lat), 32'(N1));
        check({nome, "_ocup"}, 32'(n_ocup), 32'(N1 + 1));
        check({nome, "_hold"}, 32'(soma_w), 32'(sw));
    endtask

    task automatic op2(input string nome, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] sw, input logic ow);
        int lat;
        int n_ocup;
        @(negedge clock);
        a2 = a; b2 = b; sinal2 = s; inicio2 = 1'b1;
        @(posedge clock); #1;
        q_2.push_back({sw, ow});
        inicio2 = 1'b0; a2 = ~a; b2 = ~b; sinal2 = ~s;
        lat = -1;
        n_ocup = 0;
        for (int c = 0; c < 20; c++) begin
            if (!ocup_2) break;
            n_ocup++;
            if (pronto_2 && lat < 0) lat = c;
            @(posedge clock); #1;
        end
        check({nome, "_lat"}, 32'(lat), 32'(N2));
        check({nome, "_ocup"}, 32'(n_ocup), 32'(N2 + 1));
    endtask

    initial begin
        int   n_acc;
        int   t_acc[3];
        logic prev;

        reset = 1'b1;
        inicio1 = 1'b0; inicio2 = 1'b0; sinal1 = 1'b0; sinal2 = 1'b0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ocup_w", 32'(ocup_w), 32'd0);
        check("rst_pronto_w", 32'(pronto_w), 32'd0);
        check("rst_soma_w", 32'(soma_w), 32'd0);
        check("rst_ovf_w", 32'(ovf_w), 32'd0);
        check("rst_soma_s", 32'(soma_s), 32'd0);
        check("rst_soma_2", 32'(soma_2), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        //   name      a       b       s     wrap         sat          pulse
        op1("add",    9'h1FF, 9'h004, 1'b0, 9'h003, 1'b0, 9'h003, 1'b0, 1'b0);
        op1("sub",    9'h1FF, 9'h004, 1'b1, 9'h1FB, 1'b0, 9'h1FB, 1'b0, 1'b0);
        op1("posovf", 9'h0C8, 9'h064, 1'b0, 9'h12C, 1'b1, 9'h0FF, 1'b1, 1'b0);
        op1("negovf", 9'h138, 9'h064, 1'b1, 9'h0D4, 1'b1, 9'h100, 1'b1, 1'b0);
        op1("negmin", 9'h000, 9'h100, 1'b1, 9'h100, 1'b1, 9'h0FF, 1'b1, 1'b0);
        op1("limits", 9'h0FF, 9'h100, 1'b0, 9'h1FF, 1'b0, 9'h1FF, 1'b0, 1'b0);
        op1("minm1",  9'h100, 9'h001, 1'b1, 9'h0FF, 1'b1, 9'h100, 1'b1, 1'b0);

        // Reset two edges into a running add: no pronto, outputs cleared.
        @(negedge clock);
        a1 = 9'h010; b1 = 9'h020; sinal1 = 1'b0; inicio1 = 1'b1;
        @(posedge clock); #1;
        inicio1 = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_ocup_w", 32'(ocup_w), 32'd0);
        check("midrst_pronto_w", 32'(pronto_w), 32'd0);
        check("midrst_soma_w", 32'(soma_w), 32'd0);
        check("midrst_ovf_w", 32'(ovf_w), 32'd0);
        check("midrst_soma_s", 32'(soma_s), 32'd0);
        check("midrst_ovf_s", 32'(ovf_s), 32'd0);
        reset = 1'b0;
        repeat (6) @(posedge clock);

        op1("fresh",  9'h0AA, 9'h055, 1'b0, 9'h0FF, 1'b0, 9'h0FF, 1'b0, 1'b0);
        op1("pulse",  9'h0F0, 9'h00F, 1'b1, 9'h0E1, 1'b0, 9'h0E1, 1'b0, 1'b1);

        // inicio held high: accepts spaced N+2 cycles apart.
        @(negedge clock);
        a1 = 9'h005; b1 = 9'h007; sinal1 = 1'b0; inicio1 = 1'b1;
        n_acc = 0;
        t_acc = '{0, 0, 0};
        prev = 1'b0;
        for (int c = 0; c < 40 && n_acc < 3; c++) begin
            @(posedge clock); #1;
            if (ocup_w && !prev) begin
                t_acc[n_acc] = c;
                n_acc++;
                q_w.push_back({7'd0, 9'h00C, 1'b0});
                q_s.push_back({7'd0, 9'h00C, 1'b0});
            end
            prev = ocup_w;
        end
        inicio1 = 1'b0;
        check("hold_accepts", 32'(n_acc), 32'd3);
        check("hold_gap1", 32'(t_acc[1] - t_acc[0]), 32'(N1 + 2));
        check("hold_gap2", 32'(t_acc[2] - t_acc[1]), 32'(N1 + 2));
        repeat (8) @(posedge clock);

        op2("w16_add",  16'hFFFF, 16'h0004, 1'b0, 16'h0003, 1'b0);
        op2("w16_sub",  16'hFFFF, 16'h0004, 1'b1, 16'hFFFB, 1'b0);
        op2("w16_big",  16'h00C8, 16'h0064, 1'b0, 16'h012C, 1'b0);
        op2("w16_povf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
        op2("w16_novf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);

        repeat (5) @(posedge clock);
        #1;
        check("left_w", 32'(q_w.size()), 32'd0);
        check("left_s", 32'(q_s.size()), 32'd0);
        check("left_2", 32'(q_2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
